// File: rtl/auto_load_multi_pkg.sv
// Shared constants for the multi-region BPI constant auto-loader: BPI command
// values, sequencer state encodings and a saturating counter helper.
package auto_load_multi_pkg;

    typedef logic [2:0] al_state_t;

    localparam logic [15:0] READ_ARRAY_CMD = 16'h00FF;
    localparam logic [1:0]  OP_READ        = 2'b10;

    localparam al_state_t S_IDLE      = 3'd0;
    localparam al_state_t S_START     = 3'd1;
    localparam al_state_t S_WAIT_BUS  = 3'd2;
    localparam al_state_t S_EXEC      = 3'd3;
    localparam al_state_t S_WAIT_DONE = 3'd4;
    localparam al_state_t S_CAPTURE   = 3'd5;
    localparam al_state_t S_COMPLETE  = 3'd6;
    localparam al_state_t S_ABORT     = 3'd7;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/auto_load_seq_fsm.sv
// Load sequencer: walks each word through bus wait, launch and completion,
// with a per-word timeout and a bounded number of relaunches.
module auto_load_seq_fsm
    import auto_load_multi_pkg::*;
#(
    parameter int TIMEOUT   = 4096,
    parameter int MAX_RETRY = 2
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      start,
    input  logic      abort,
    input  logic      busy,
    input  logic      done,
    input  logic      last_word,
    output al_state_t state,
    output logic      start_accept,
    output logic      retry_pulse
);

    localparam int              TMR_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
    localparam logic [1:0]      RETRY_MAX = 2'(MAX_RETRY);

    al_state_t        state_reg, state_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic [1:0]       retry_reg, retry_next;

    assign state        = state_reg;
    assign start_accept = (state_reg == S_IDLE) && start;

    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        retry_next  = retry_reg;
        retry_pulse = 1'b0;
        case (state_reg)
            S_IDLE:      if (start) state_next = S_START;
            S_START: begin
                retry_next = 2'd0;
                state_next = S_WAIT_BUS;
            end
            S_WAIT_BUS:  if (!busy) state_next = S_EXEC;
            S_EXEC: begin
                timer_next = TMR_LOAD;
                state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // A completion arriving on the expiry cycle still counts.
                if (done) begin
                    state_next = S_CAPTURE;
                end else if (timer_reg == '0) begin
                    if (retry_reg < RETRY_MAX) begin
                        retry_next  = retry_reg + 2'd1;
                        retry_pulse = 1'b1;
                        state_next  = S_WAIT_BUS;
                    end else begin
                        state_next = S_ABORT;
                    end
                end else begin
                    timer_next = timer_reg - TMR_W'(1);
                end
            end
            S_CAPTURE: begin
                retry_next = 2'd0;
                state_next = last_word ? S_COMPLETE : S_WAIT_BUS;
            end
            S_COMPLETE:  state_next = S_IDLE;
            S_ABORT:     state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
        // External abort overrides completion and timeout alike.
        if (abort && (state_reg != S_IDLE) && (state_reg != S_ABORT)) begin
            state_next  = S_ABORT;
            retry_pulse = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= S_IDLE;
            timer_reg <= '0;
            retry_reg <= 2'd0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            retry_reg <= retry_next;
        end
    end

endmodule

// File: rtl/auto_load_multi.sv
// Multi-region constant auto-loader: reads NWORDS flash words from a selected
// parameter region over the BPI command interface into the constant RAM.
module auto_load_multi
    import auto_load_multi_pkg::*;
#(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 23'h7FC000,
    parameter logic [ADDR_W-1:0] REG_STRIDE = 23'h000040,
    parameter int                NREG       = 2,
    parameter int                RSEL_W     = 1,
    parameter int                NWORDS     = 34,
    parameter int                CNT_W      = 6,
    parameter int                TIMEOUT    = 4096,
    parameter int                MAX_RETRY  = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              AL_START,
    input  logic [RSEL_W-1:0] AL_REGION,
    input  logic              AL_ABORT,
    input  logic              BUSY,
    input  logic              AL_DONE,
    input  logic [15:0]       AL_RDATA,
    output logic [ADDR_W-1:0] AL_ADDR,
    output logic [15:0]       AL_CMD_DATA_OUT,
    output logic [1:0]        AL_OP,
    output logic              AL_EXECUTE,
    output logic              AUTO_LOAD_ENA,
    output logic              CLR_AL_DONE,
    output logic [CNT_W-1:0]  AL_CNT,
    output logic              AL_WE,
    output logic [CNT_W-1:0]  AL_WADDR,
    output logic [15:0]       AL_WDATA,
    output logic [2:0]        AL_STATUS,
    output logic [7:0]        AL_RETRIES
);

    localparam logic [RSEL_W-1:0] SEL_MAX  = RSEL_W'(NREG - 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NWORDS - 1);

    al_state_t         fsm_state;
    logic              start_accept;
    logic              retry_pulse;
    logic              last_word;
    logic [31:0]       region_ext;
    logic [RSEL_W-1:0] sel_reg, sel_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [2:0]        status_reg;
    logic [7:0]        retries_reg;

    // Out-of-range region requests fall back to the highest region.
    assign region_ext = 32'(AL_REGION);
    assign sel_next   = (region_ext >= 32'(NREG)) ? SEL_MAX : AL_REGION;
    assign last_word  = (cnt_reg == LAST_IDX);

    auto_load_seq_fsm #(
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) u_fsm (
        .CLK          (CLK),
        .RST          (RST),
        .start        (AL_START),
        .abort        (AL_ABORT),
        .busy         (BUSY),
        .done         (AL_DONE),
        .last_word    (last_word),
        .state        (fsm_state),
        .start_accept (start_accept),
        .retry_pulse  (retry_pulse)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            sel_reg     <= '0;
            cnt_reg     <= '0;
            status_reg  <= 3'b000;
            retries_reg <= 8'd0;
        end else begin
            if (start_accept) sel_reg <= sel_next;
            case (fsm_state)
                S_START: begin
                    cnt_reg         <= '0;
                    retries_reg     <= 8'd0;
                    status_reg[2:1] <= 2'b00;
                end
                S_CAPTURE: begin
                    status_reg[0] <= 1'b1;
                    if (!last_word) cnt_reg <= cnt_reg + CNT_W'(1);
                end
                S_COMPLETE: status_reg[1] <= 1'b1;
                S_ABORT:    status_reg[2] <= 1'b1;
                default: ;
            endcase
            if (retry_pulse) retries_reg <= sat_inc8(retries_reg);
        end
    end

    assign AUTO_LOAD_ENA   = (fsm_state != S_IDLE);
    assign AL_EXECUTE      = (fsm_state == S_EXEC);
    assign AL_WE           = (fsm_state == S_CAPTURE);
    assign CLR_AL_DONE     = AL_WE || (fsm_state == S_ABORT);
    // The address bus is only driven while this block owns the BPI interface.
    assign AL_ADDR         = AUTO_LOAD_ENA
                           ? BASE_ADDR + ADDR_W'(sel_reg) * REG_STRIDE + ADDR_W'(cnt_reg)
                           : '0;
    assign AL_CMD_DATA_OUT = READ_ARRAY_CMD;
    assign AL_OP           = OP_READ;
    assign AL_CNT          = cnt_reg;
    assign AL_WADDR        = cnt_reg;
    assign AL_WDATA        = AL_WE ? AL_RDATA : 16'h0000;
    assign AL_STATUS       = status_reg;
    assign AL_RETRIES      = retries_reg;

endmodule
